// File: rtl/axi_ram_slave.sv
// axi_ram_slave: AXI4 memory responder with 32-bit words.
// Writes and reads run independently. Each direction allows one burst in
// flight, and bursts complete in order. The RAM contents survive reset.
module axi_ram_slave #(
  parameter int ADDR_W = 29,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  // write address
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic [7:0]        s_axi_awlen,
  input  logic [2:0]        s_axi_awsize,
  input  logic [1:0]        s_axi_awburst,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  // write data
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wlast,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  // write response
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  // read address
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic [7:0]        s_axi_arlen,
  input  logic [2:0]        s_axi_arsize,
  input  logic [1:0]        s_axi_arburst,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  // read data
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rlast,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready
);

  localparam int WIDX_W = ADDR_W - 2;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WIDX_W:0] DEPTH_L = (WIDX_W+1)'(DEPTH);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  // Burst command latched at the address handshake. The addr field tracks
  // the address of the current beat.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
  } cmd_t;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  // Response for one beat, without the wlast check. Out-of-range words
  // report DECERR. A bad size or burst type reports SLVERR.
  function automatic logic [1:0] beat_chk(input logic [WIDX_W-1:0] widx,
                                          input logic [2:0] sz,
                                          input logic [1:0] bu);
    if ({1'b0, widx} >= DEPTH_L)        return RESP_DECERR;
    else if (sz != 3'd2 || bu[1])       return RESP_SLVERR;
    else                                return RESP_OKAY;
  endfunction

  // The encodings are ordered by severity, so a numeric max picks the
  // worst response.
  function automatic logic [1:0] rmax(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  // INCR steps one word and wraps at 2^ADDR_W. FIXED and illegal bursts
  // keep the same address.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                  input logic [1:0] bu);
    return (bu == BURST_INCR) ? a + ADDR_W'(4) : a;
  endfunction

  logic [31:0] mem [DEPTH];

  // ---------------- write channel ----------------
  w_state_t    w_state;
  cmd_t        w_cmd;
  logic [7:0]  w_cnt;
  logic [1:0]  w_err;

  logic        w_beat;
  logic        w_last_exp;
  logic [1:0]  w_resp_beat;
  logic        w_we;
  logic [MEM_AW-1:0] w_idx;

  // Classify the current W beat and decide whether it reaches the RAM.
  always_comb begin
    w_beat      = (w_state == W_DATA) && s_axi_wvalid && s_axi_wready;
    w_last_exp  = (w_cnt == w_cmd.len);
    w_resp_beat = beat_chk(w_cmd.addr[ADDR_W-1:2], w_cmd.size, w_cmd.burst);
    if (w_resp_beat == RESP_OKAY && s_axi_wlast != w_last_exp)
      w_resp_beat = RESP_SLVERR;
    w_we        = w_beat && (w_resp_beat == RESP_OKAY);
    w_idx       = w_cmd.addr[MEM_AW+1:2];
  end

  // Write FSM. All handshake outputs are registered. awready is first set
  // by the first edge after reset is released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state       <= W_IDLE;
      w_cmd         <= '0;
      w_cnt         <= '0;
      w_err         <= RESP_OKAY;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (s_axi_awvalid && s_axi_awready) begin
            w_cmd         <= '{addr: s_axi_awaddr, len: s_axi_awlen,
                               size: s_axi_awsize, burst: s_axi_awburst};
            w_cnt         <= '0;
            w_err         <= RESP_OKAY;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b1;
            w_state       <= W_DATA;
          end else begin
            s_axi_awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_beat) begin
            w_cmd.addr <= next_addr(w_cmd.addr, w_cmd.burst);
            if (w_last_exp) begin
              s_axi_wready <= 1'b0;
              s_axi_bvalid <= 1'b1;
              s_axi_bresp  <= rmax(w_err, w_resp_beat);
              w_state      <= W_RESP;
            end else begin
              w_cnt <= w_cnt + 8'd1;
              w_err <= rmax(w_err, w_resp_beat);
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
            s_axi_awready <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // RAM write port. It has no reset so the contents survive rst.
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int b = 0; b < 4; b++)
        if (s_axi_wstrb[b]) mem[w_idx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
    end
  end

  // ---------------- read channel ----------------
  r_state_t    r_state;
  cmd_t        r_cmd;
  logic [7:0]  r_cnt;

  logic              r_ld_idle;
  logic              r_ld_next;
  logic [ADDR_W-1:0] ld_addr;
  logic [2:0]        ld_size;
  logic [1:0]        ld_burst;
  logic [1:0]        ld_resp;
  logic [31:0]       ld_data;

  // Select the beat to load: beat 0 comes straight from AR, later beats
  // come from the tracked address. The RAM is read combinationally, so
  // a write on the same edge is not yet visible to the load.
  always_comb begin
    r_ld_idle = (r_state == R_IDLE) && s_axi_arvalid && s_axi_arready;
    r_ld_next = (r_state == R_DATA) && s_axi_rvalid && s_axi_rready && !s_axi_rlast;
    ld_addr   = r_cmd.addr;
    ld_size   = r_cmd.size;
    ld_burst  = r_cmd.burst;
    if (r_state == R_IDLE) begin
      ld_addr  = s_axi_araddr;
      ld_size  = s_axi_arsize;
      ld_burst = s_axi_arburst;
    end
    ld_resp = beat_chk(ld_addr[ADDR_W-1:2], ld_size, ld_burst);
    ld_data = (ld_resp == RESP_OKAY) ? mem[ld_addr[MEM_AW+1:2]] : 32'h0;
  end

  // Read FSM. After a beat is accepted, the next beat loads on the same
  // edge, so beats follow with no idle cycle between them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= R_IDLE;
      r_cmd         <= '0;
      r_cnt         <= '0;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= RESP_OKAY;
      s_axi_rlast   <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (r_ld_idle) begin
            r_cmd         <= '{addr: next_addr(s_axi_araddr, s_axi_arburst),
                               len: s_axi_arlen, size: s_axi_arsize,
                               burst: s_axi_arburst};
            r_cnt         <= '0;
            s_axi_rdata   <= ld_data;
            s_axi_rresp   <= ld_resp;
            s_axi_rlast   <= (s_axi_arlen == 8'd0);
            s_axi_rvalid  <= 1'b1;
            s_axi_arready <= 1'b0;
            r_state       <= R_DATA;
          end else begin
            s_axi_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_axi_rvalid && s_axi_rready) begin
            if (s_axi_rlast) begin
              s_axi_rvalid  <= 1'b0;
              s_axi_rlast   <= 1'b0;
              s_axi_rdata   <= '0;
              s_axi_rresp   <= RESP_OKAY;
              s_axi_arready <= 1'b1;
              r_state       <= R_IDLE;
            end else if (r_ld_next) begin
              r_cmd.addr  <= next_addr(ld_addr, ld_burst);
              r_cnt       <= r_cnt + 8'd1;
              s_axi_rdata <= ld_data;
              s_axi_rresp <= ld_resp;
              s_axi_rlast <= ((r_cnt + 8'd1) == r_cmd.len);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_ram_slave.sv
// tb_axi_ram_slave: directed-vector bench for axi_ram_slave.
// Inputs change on the falling edge. Outputs are sampled on the falling
// edge, away from the active rising edge.
module tb_axi_ram_slave;
  localparam int ADDR_W = 29;
  localparam int DEPTH  = 1024;
  localparam int TMO    = 200;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [ADDR_W-1:0] awaddr = '0, araddr = '0;
  logic [7:0]        awlen = '0, arlen = '0;
  logic [2:0]        awsize = 3'd2, arsize = 3'd2;
  logic [1:0]        awburst = 2'b01, arburst = 2'b01;
  logic              awvalid = 1'b0, arvalid = 1'b0;
  logic              awready, arready;
  logic [31:0]       wdata = '0;
  logic [3:0]        wstrb = 4'hF;
  logic              wlast = 1'b0, wvalid = 1'b0, wready;
  logic [1:0]        bresp;
  logic              bvalid, bready = 1'b0;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rlast, rvalid, rready = 1'b0;

  axi_ram_slave #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;

  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic [31:0] rdd [16];
  logic [1:0]  rrs [16];
  logic        rls [16];
  int          rn;
  logic [1:0]  br;
  int          hold_bad;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Address-phase handshake. Called and returns on a falling edge.
  task automatic aw_req(input logic [ADDR_W-1:0] a, input logic [7:0] l,
                        input logic [2:0] sz, input logic [1:0] bu);
    int n = 0;
    awaddr = a; awlen = l; awsize = sz; awburst = bu; awvalid = 1'b1;
    while (!awready && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) chk("aw_timeout", 32'd1, 32'd0);
    @(negedge clk);
    awvalid = 1'b0;
  endtask

  // Send n beats from wd/ws; wlast is set on beat index len, or inverted when badlast.
  task automatic w_beats(input int n, input int len, input bit badlast);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      wdata = wd[i]; wstrb = ws[i]; wlast = (i == len) ^ badlast; wvalid = 1'b1;
      while (!wready && t < TMO) begin @(negedge clk); t++; end
      if (t >= TMO) chk("w_timeout", 32'd1, 32'd0);
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic b_take(output logic [1:0] r);
    int n = 0;
    bready = 1'b1;
    while (!bvalid && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) chk("b_timeout", 32'd1, 32'd0);
    r = bresp;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input int len, input logic [2:0] sz,
                    input logic [1:0] bu, input bit badlast, output logic [1:0] r);
    aw_req(a, 8'(len), sz, bu);
    w_beats(len + 1, len, badlast);
    b_take(r);
  endtask

  // Read burst; beats land in rdd/rrs/rls. toggle alternates rready each cycle.
  task automatic rd(input logic [ADDR_W-1:0] a, input int len, input logic [1:0] bu,
                    input bit toggle);
    int n = 0;
    bit done = 0;
    araddr = a; arlen = 8'(len); arsize = 3'd2; arburst = bu; arvalid = 1'b1;
    while (!arready && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) chk("ar_timeout", 32'd1, 32'd0);
    @(negedge clk);
    arvalid = 1'b0;
    rn = 0; n = 0;
    while (!done && n < TMO) begin
      rready = toggle ? n[0] : 1'b1;
      if (rvalid && rready && rn < 16) begin
        rdd[rn] = rdata; rrs[rn] = rresp; rls[rn] = rlast;
        rn++;
        done = rlast;
      end
      @(negedge clk);
      n++;
    end
    rready = 1'b0;
    if (!done) chk("r_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin wd[i] = '0; ws[i] = 4'hF; rdd[i] = '0; rrs[i] = '0; rls[i] = 0; end
    rn = 0; hold_bad = 0; br = '0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_awready", awready, 0);
    chk("rst_outs", {wready, bvalid, arready, rvalid, rlast}, 0);
    rst = 1'b1;
    chk("rel_awready_low", awready, 0);
    @(negedge clk);
    chk("rel_ready", {awready, arready}, 2'b11);

    // 1: single write and readback
    wd[0] = 32'hDEADBEEF;
    wr(29'h10, 0, 3'd2, 2'b01, 0, br);
    chk("t1_bresp", br, 2'b00);
    rd(29'h10, 0, 2'b01, 0);
    chk("t1_rdata", rdd[0], 32'hDEADBEEF);
    chk("t1_rresp_rlast", {rrs[0], rls[0], 29'(rn)}, {2'b00, 1'b1, 29'd1});

    // 2: byte strobes
    wd[0] = 32'hAAAAAAAA;
    wr(29'h14, 0, 3'd2, 2'b01, 0, br);
    wd[0] = 32'h11223344; ws[0] = 4'b0101;
    wr(29'h14, 0, 3'd2, 2'b01, 0, br);
    ws[0] = 4'hF;
    chk("t2_bresp", br, 2'b00);
    rd(29'h14, 0, 2'b01, 0);
    chk("t2_rdata", rdd[0], 32'hAA22AA44);

    // 3: INCR len3 with rready toggling, FIXED len3
    for (int i = 0; i < 4; i++) wd[i] = 32'(i + 1);
    wr(29'h0, 3, 3'd2, 2'b01, 0, br);
    chk("t3_incr_bresp", br, 2'b00);
    rd(29'h0, 3, 2'b01, 1);
    chk("t3_beats", rn, 4);
    chk("t3_data", {rdd[0][7:0], rdd[1][7:0], rdd[2][7:0], rdd[3][7:0]}, 32'h01020304);
    chk("t3_rlast", {rls[0], rls[1], rls[2], rls[3]}, 4'b0001);
    for (int i = 0; i < 4; i++) wd[i] = 32'(i + 5);
    wr(29'h20, 3, 3'd2, 2'b00, 0, br);
    chk("t3_fixed_bresp", br, 2'b00);
    rd(29'h20, 0, 2'b01, 0);
    chk("t3_fixed_data", rdd[0], 32'd8);

    // 4: decode and slave errors
    wd[0] = 32'h0FFC0FFC;
    wr(29'hFFC, 0, 3'd2, 2'b01, 0, br);
    wd[0] = 32'hBADBAD00;
    wr(29'(DEPTH * 4), 0, 3'd2, 2'b01, 0, br);
    chk("t4_decerr_bresp", br, 2'b11);
    rd(29'h0, 0, 2'b01, 0);
    chk("t4_word0_kept", rdd[0], 32'd1);
    rd(29'(DEPTH * 4), 0, 2'b01, 0);
    chk("t4_decerr_read", {rdd[0], 2'b00}, 34'h0);
    chk("t4_decerr_rresp", {rrs[0], rls[0]}, {2'b11, 1'b1});
    wd[0] = 32'h30303030;
    wr(29'h30, 0, 3'd2, 2'b01, 0, br);
    wd[0] = 32'hFFFFFFFF;
    wr(29'h30, 0, 3'd1, 2'b01, 0, br);
    chk("t4_size_slverr", br, 2'b10);
    rd(29'h30, 0, 2'b01, 0);
    chk("t4_size_nowrite", rdd[0], 32'h30303030);
    wr(29'h38, 0, 3'd2, 2'b10, 0, br);
    chk("t4_burst_slverr", br, 2'b10);
    wr(29'h34, 1, 3'd2, 2'b01, 1, br);
    chk("t4_wlast_slverr", br, 2'b10);
    rd(29'hFFC, 1, 2'b01, 0);
    chk("t4_cross_beat0", {rdd[0], rrs[0], rls[0]}, {32'h0FFC0FFC, 2'b00, 1'b0});
    chk("t4_cross_beat1", {rdd[1], rrs[1], rls[1]}, {32'h0, 2'b11, 1'b1});

    // 5: B stalled 10 cycles while a read completes
    wd[0] = 32'h40404040;
    aw_req(29'h40, 8'd0, 3'd2, 2'b01);
    w_beats(1, 0, 0);
    fork
      begin
        for (int c = 0; c < 10; c++) begin
          if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0) hold_bad++;
          @(negedge clk);
        end
      end
      rd(29'h0, 1, 2'b01, 0);
    join
    chk("t5_b_hold", hold_bad, 0);
    chk("t5_read_during", {rdd[0][7:0], rdd[1][7:0], 14'(rn), rls[1]}, {8'd1, 8'd2, 14'd2, 1'b1});
    b_take(br);
    chk("t5_bresp", br, 2'b00);
    rd(29'h40, 0, 2'b01, 0);
    chk("t5_data", rdd[0], 32'h40404040);

    // 6: reset in the middle of a write burst
    wd[0] = 32'h0000050A; wd[1] = 32'h0000050B; wd[2] = 32'h0000050C; wd[3] = 32'h0000050D;
    aw_req(29'h50, 8'd3, 3'd2, 2'b01);
    w_beats(2, 3, 0);
    rst = 1'b0;
    #1;
    chk("t6_rst_outs", {awready, wready, bvalid, arready, rvalid}, 5'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_awready_back", awready, 1);
    wd[0] = 32'h60606060;
    wr(29'h60, 0, 3'd2, 2'b01, 0, br);
    chk("t6_next_bresp", br, 2'b00);
    rd(29'h50, 1, 2'b01, 0);
    chk("t6_kept", {rdd[0], rdd[1]}, {32'h0000050A, 32'h0000050B});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  // Overall watchdog so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
